irq_ctrl: RTL
=============

Name: irq_ctrl

Overview:
- Interrupt controller directly upstream of the control unit.
- Synchronises and edge-detects external interrupt lines and latches them into a pending register with a programmable mask.
- Requests service over O_irq_active / I_irq_ack and supplies the winning interrupt number within the control unit's two-cycle irq-number fetch window.
- Holds that number as in-service until end-of-interrupt (EOI). Nesting is not supported.

Parameters:
- NUM_IRQ, 8, number of interrupt lines; legal range 2..16.
- IRQ_NUM_WIDTH, 3, width of O_irq_number; must satisfy 2^IRQ_NUM_WIDTH >= NUM_IRQ.
- SYNC_STAGES, 2, flip-flop stages per input synchroniser; minimum 2.

Ports:
- I_clk  input  1  system clock; all logic on rising edge.
- I_reset_n  input  1  reset, asynchronous assert, active-low.
- I_irq_lines  input  NUM_IRQ  asynchronous interrupt sources; request on rising edge.
- I_mask_we  input  1  mask write strobe.
- I_mask_data  input  NUM_IRQ  new mask value; bit=1 disables that line.
- I_irq_ack  input  1  acknowledge from control unit.
- I_eoi  input  1  end-of-interrupt pulse from ISR return.
- O_irq_active  output  1  service request to control unit.
- O_irq_number  output  IRQ_NUM_WIDTH  interrupt number being serviced.
- O_in_service  output  1  high from ack until EOI.
- O_pending  output  NUM_IRQ  raw pending register, for status reads.
- O_mask  output  NUM_IRQ  current mask register.

Behaviour:
- Reset (I_reset_n=0, takes effect asynchronously at any time, including mid-handshake):
  - O_irq_active=0, O_irq_number=0, O_in_service=0, O_pending=0.
  - O_mask=all ones (all lines masked); synchroniser and edge-history flops=0.
  - FSM returns to IDLE.
- Synchronise and edge-detect:
  - Each line passes through SYNC_STAGES flops, then one history flop.
  - A rising edge (sync=1, history=0) sets the pending bit.
  - Input rising before edge k → pending bit set at edge k+SYNC_STAGES.
  - Level-held lines do not re-trigger; a new edge is needed.
- Pending clear: a bit clears only when its number is captured at ack. If a new edge on the same line arrives in the same cycle, set wins and the bit stays 1.
- Mask:
  - I_mask_we=1 loads I_mask_data at the next edge.
  - Masked lines still set pending but are not eligible for request.
  - eligible = pending & ~mask.
- Priority: lowest eligible index wins (line 0 highest).
- FSM states: IDLE, REQUEST, IN_SERVICE.
  - IDLE: if eligible!=0 → REQUEST; O_irq_active=1 from the next edge.
  - REQUEST, I_irq_ack=1 at edge:
    - Capture the highest-priority eligible index into O_irq_number.
    - Clear that pending bit; O_irq_active=0; O_in_service=1.
    - Go to IN_SERVICE.
    - O_irq_number is valid from the edge after ack and stable until the next capture, which satisfies the control unit's 2-cycle fetch wait.
  - REQUEST, eligible becomes 0 (mask write) before ack: → IDLE, O_irq_active=0 at next edge.
  - REQUEST, ack and eligible=0 in the same cycle: ack ignored, → IDLE.
  - IN_SERVICE: no request, regardless of pending state. I_eoi=1 → IDLE, O_in_service=0.
  - A pending eligible line re-requests at earliest 1 cycle after EOI (IDLE→REQUEST).
- I_eoi outside IN_SERVICE and I_irq_ack outside REQUEST: ignored, no state change.
- Simultaneous edges on several lines: all pending bits set. They are serviced one per ack/EOI round, in priority order.
- O_irq_number is never altered by mask writes or EOI; only an ack capture changes it.

Test Plan:
- Reset then mask=0x00; pulse line 5 → pending=0x20 after SYNC_STAGES edges, O_irq_active=1 one edge later; ack → O_irq_number=5, pending=0x00, O_in_service=1; EOI → O_in_service=0, active stays 0.
- Lines 6 and 2 rise in the same cycle, mask=0x00 → first ack yields 2, pending=0x40; after EOI, active reasserts; second ack yields 6.
- Mask=0xFF, pulse line 3 → pending=0x08, active stays 0; write mask=0xF7 → active=1 within 2 edges; ack → number=3.
- In REQUEST with only line 4 eligible, write mask=0x10 → active drops next edge, FSM=IDLE, pending=0x10 retained; ack pulse then ignored (number unchanged).
- In IN_SERVICE for line 1, a new line 1 edge arrives → pending=0x02, no request until EOI; EOI → active=1 next edge; edge coinciding with ack keeps pending bit set.
- Assert I_reset_n=0 mid-REQUEST (asynchronously, between edges) → all outputs reset immediately, mask=all ones; release reset → no spurious request, even with lines held high.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller in front of the control unit.
// Per-line synchroniser + rising-edge detect + pending bit, a mask register,
// a fixed-priority (line 0 highest) selector and a non-nesting
// IDLE/REQUEST/IN_SERVICE handshake FSM.

module irq_ctrl_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic I_clk,
    input  logic I_reset_n,
    input  logic I_line,
    input  logic I_clr,
    output logic O_pend
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise;

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

    // Synchroniser chain, edge history and pending bit; a new edge beats a clear
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            O_pend <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], I_line};
            hist_q <= sync_q[SYNC_STAGES-1];
            O_pend <= rise | (O_pend & ~I_clr);
        end
    end
endmodule

module irq_ctrl #(
    parameter int NUM_IRQ       = 8,
    parameter int IRQ_NUM_WIDTH = 3,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     I_clk,
    input  logic                     I_reset_n,
    input  logic [NUM_IRQ-1:0]       I_irq_lines,
    input  logic                     I_mask_we,
    input  logic [NUM_IRQ-1:0]       I_mask_data,
    input  logic                     I_irq_ack,
    input  logic                     I_eoi,
    output logic                     O_irq_active,
    output logic [IRQ_NUM_WIDTH-1:0] O_irq_number,
    output logic                     O_in_service,
    output logic [NUM_IRQ-1:0]       O_pending,
    output logic [NUM_IRQ-1:0]       O_mask
);
    typedef enum logic [1:0] {IDLE, REQUEST, IN_SERVICE} state_t;

    state_t                   state;
    logic [NUM_IRQ-1:0]       elig;
    logic [NUM_IRQ-1:0]       grant;
    logic [NUM_IRQ-1:0]       clr;
    logic [IRQ_NUM_WIDTH-1:0] win;
    logic                     take;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_lane
        irq_ctrl_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
            .I_clk    (I_clk),
            .I_reset_n(I_reset_n),
            .I_line   (I_irq_lines[g]),
            .I_clr    (clr[g]),
            .O_pend   (O_pending[g])
        );
    end

    // Masked lines still latch pending; they just never compete
    assign elig  = O_pending & ~O_mask;
    // Isolate the lowest set bit: that line is the one cleared on capture
    assign grant = elig & (~elig + NUM_IRQ'(1));
    // An ack only counts in REQUEST while something is still eligible
    assign take  = (state == REQUEST) && I_irq_ack && (elig != '0);
    assign clr   = take ? grant : '0;

    // Lowest eligible index wins; scan downward so index 0 overrides
    always_comb begin
        win = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) win = IRQ_NUM_WIDTH'(i);
        end
    end

    // Mask register; comes out of reset with every line disabled
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n)     O_mask <= '1;
        else if (I_mask_we) O_mask <= I_mask_data;
    end

    // Handshake FSM with registered outputs; the number changes only on capture
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state        <= IDLE;
            O_irq_active <= 1'b0;
            O_irq_number <= '0;
            O_in_service <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (elig != '0) begin
                        state        <= REQUEST;
                        O_irq_active <= 1'b1;
                    end
                end
                REQUEST: begin
                    if (elig == '0) begin
                        state        <= IDLE;
                        O_irq_active <= 1'b0;
                    end else if (I_irq_ack) begin
                        state        <= IN_SERVICE;
                        O_irq_active <= 1'b0;
                        O_in_service <= 1'b1;
                        O_irq_number <= win;
                    end
                end
                IN_SERVICE: begin
                    if (I_eoi) begin
                        state        <= IDLE;
                        O_in_service <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    O_irq_active <= 1'b0;
                    O_in_service <= 1'b0;
                end
            endcase
        end
    end
endmodule
